// File: rtl/pf_video_pkg.sv
// Shared playfield video definitions: load-sequencer states and bus widths.
package pf_video_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, LOAD, HOLD} vsl_state_t;

    localparam int PF_SCROLL_W = 9;
    localparam int VBD_W       = 16;

endpackage

// File: rtl/playfield_vscroll_loader_edge_detect.sv
// Registered level follower reporting rising and falling edges; silent for the
// first cycle after reset so a level already high at release is not an edge.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic r_q;
    logic r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= 1'b0;
            r_vld <= 1'b0;
        end else begin
            r_q   <= d;
            r_vld <= 1'b1;
        end
    end

    assign rise = r_vld &  d & ~r_q;
    assign fall = r_vld & ~d &  r_q;

endmodule

// File: rtl/playfield_vscroll_loader.sv
// Vertical-scroll load sequencer: double-buffers the CPU scroll value and drives
// VBD/VSCRLD to the scroll line counter on VBLANK rise or a requested HSYNC split.
module playfield_vscroll_loader
    import pf_video_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int LOAD_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_we,
    input  logic [PF_SCROLL_W-1:0] cpu_data,
    input  logic                   cpu_split,
    input  logic                   VBLANK,
    input  logic                   HSYNC,
    output logic [VBD_W-1:0]       VBD,
    output logic                   VBD_OE,
    output logic                   VSCRLD,
    output logic                   BUSY
);

    localparam int MAX_SL = (SETUP_CYCLES > LOAD_CYCLES) ? SETUP_CYCLES : LOAD_CYCLES;
    localparam int MAX_C  = (MAX_SL > HOLD_CYCLES) ? MAX_SL : HOLD_CYCLES;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(HOLD_CYCLES - 1);

    vsl_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [PF_SCROLL_W-1:0] r_shadow;
    logic [PF_SCROLL_W-1:0] r_active;
    logic                   r_split_pend;
    logic                   r_trig_pend;

    logic w_vb_rise;
    logic w_vb_fall_unused;
    logic w_hs_rise_unused;
    logic w_hs_fall;
    logic w_split_trig;
    logic w_trig;

    edge_detect u_vblank_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (VBLANK),
        .rise (w_vb_rise),
        .fall (w_vb_fall_unused)
    );

    edge_detect u_hsync_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (HSYNC),
        .rise (w_hs_rise_unused),
        .fall (w_hs_fall)
    );

    // A frame reload and a split can never coincide: a split needs VBLANK low.
    assign w_split_trig = w_hs_fall & ~VBLANK & r_split_pend;
    assign w_trig       = w_vb_rise | w_split_trig;

    assign VBD = VBD_OE ? {{(VBD_W - PF_SCROLL_W){1'b0}}, r_active} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_split_pend <= 1'b0;
            r_trig_pend  <= 1'b0;
            VBD_OE       <= 1'b0;
            VSCRLD       <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            if (cpu_we)
                r_shadow <= cpu_data;
            // Any trigger consumes the split request; a write later in the same cycle re-arms it.
            if (w_trig)
                r_split_pend <= 1'b0;
            if (cpu_we && cpu_split)
                r_split_pend <= 1'b1;
            if (r_state != IDLE && w_trig)
                r_trig_pend <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_trig || r_trig_pend) begin
                        r_active    <= r_shadow;
                        r_trig_pend <= 1'b0;
                        r_cnt       <= CNT_SETUP;
                        r_state     <= SETUP;
                        VBD_OE      <= 1'b1;
                        BUSY        <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= LOAD;
                        VSCRLD  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= CNT_HOLD;
                        r_state <= HOLD;
                        VSCRLD  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        VBD_OE  <= 1'b0;
                        BUSY    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_playfield_vscroll_loader.sv
// Bench for the vertical-scroll loader: directed scenarios and random traffic
// compared cycle by cycle with a timeline model of load transactions.
module tb_playfield_vscroll_loader;

    localparam int S = 1;
    localparam int L = 2;
    localparam int H = 1;
    localparam int T = S + L + H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_we = 1'b0;
    logic [8:0]  cpu_data = '0;
    logic        cpu_split = 1'b0;
    logic        VBLANK = 1'b0;
    logic        HSYNC = 1'b1;
    logic [15:0] VBD;
    logic        VBD_OE;
    logic        VSCRLD;
    logic        BUSY;

    int vectors = 0;
    int miscompares = 0;

    // Model: a transaction is its start cycle and value; outputs follow from the offset.
    int       cyc = 0;
    int       m_start = -1;
    logic [8:0] m_val = '0;
    logic [8:0] m_shadow = '0;
    bit       m_split_pend = 0;
    bit       m_pend = 0;
    bit       m_vb_q = 0;
    bit       m_hs_q = 0;
    bit       m_first = 1;

    playfield_vscroll_loader #(
        .SETUP_CYCLES(S),
        .LOAD_CYCLES (L),
        .HOLD_CYCLES (H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_we   (cpu_we),
        .cpu_data (cpu_data),
        .cpu_split(cpu_split),
        .VBLANK   (VBLANK),
        .HSYNC    (HSYNC),
        .VBD      (VBD),
        .VBD_OE   (VBD_OE),
        .VSCRLD   (VSCRLD),
        .BUSY     (BUSY)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] expected();
        int k;
        k = cyc - m_start;
        if (m_start >= 0 && k >= 0 && k < T)
            return {1'b1, (k >= S && k < S + L), 1'b1, 7'b0, m_val};
        return '0;
    endfunction

    task automatic model_reset();
        m_start = -1; m_pend = 0; m_split_pend = 0; m_shadow = '0;
        m_val = '0; m_vb_q = 0; m_hs_q = 0; m_first = 1;
    endtask

    task automatic model_step();
        bit rise, fall, trig, idle;
        if (!rst_n) begin
            model_reset();
            cyc++;
            return;
        end
        rise = !m_first && VBLANK && !m_vb_q;
        fall = !m_first && !HSYNC && m_hs_q;
        trig = rise || (fall && !VBLANK && m_split_pend);
        idle = !(m_start >= 0 && (cyc - m_start) < T);
        if (idle && (trig || m_pend)) begin
            m_start = cyc + 1;
            m_val   = m_shadow;
            m_pend  = 0;
        end else if (trig) begin
            m_pend = 1;
        end
        if (trig) m_split_pend = 0;
        if (cpu_we && cpu_split) m_split_pend = 1;
        if (cpu_we) m_shadow = cpu_data;
        m_vb_q = VBLANK;
        m_hs_q = HSYNC;
        m_first = 0;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({BUSY, VSCRLD, VBD_OE, VBD} !== 19'h0) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%h exp=0", cyc, {BUSY, VSCRLD, VBD_OE, VBD});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({BUSY, VSCRLD, VBD_OE, VBD} !== expected()) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, {BUSY, VSCRLD, VBD_OE, VBD}, expected());
            end
        end
    endtask

    task automatic test_frame_load();
        logic [18:0] seq [5];
        seq[0] = {3'b101, 16'h0123};
        seq[1] = {3'b111, 16'h0123};
        seq[2] = {3'b111, 16'h0123};
        seq[3] = {3'b101, 16'h0123};
        seq[4] = 19'h0;
        cpu_we = 1'b1; cpu_data = 9'h123; cpu_split = 1'b0;
        tick();
        cpu_we = 1'b0;
        tick();
        VBLANK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({BUSY, VSCRLD, VBD_OE, VBD} !== seq[i] || seq[i] !== expected()) begin
                miscompares++;
                $display("FAIL frame_seq step=%0d got=%h exp=%h model=%h", i, {BUSY, VSCRLD, VBD_OE, VBD}, seq[i], expected());
            end
        end
        VBLANK = 1'b0;
        tick();
    endtask

    task automatic test_split();
        cpu_we = 1'b1; cpu_data = 9'h040; cpu_split = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_split = 1'b0;
        HSYNC = 1'b0;
        tick();
        vectors++;
        if (VBD !== 16'h0040 || VBD_OE !== 1'b1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL split_load got VBD=%h OE=%b BUSY=%b exp VBD=0040 OE=1 BUSY=1", VBD, VBD_OE, BUSY);
        end
        HSYNC = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({BUSY, VSCRLD, VBD_OE, VBD} !== expected()) begin
                miscompares++;
                $display("FAIL split_seq cyc=%0d got=%h exp=%h", cyc, {BUSY, VSCRLD, VBD_OE, VBD}, expected());
            end
        end
        HSYNC = 1'b0;
        tick();
        vectors++;
        if (BUSY !== 1'b0 || VBD_OE !== 1'b0) begin
            miscompares++;
            $display("FAIL split_second got BUSY=%b OE=%b exp 0 0", BUSY, VBD_OE);
        end
        HSYNC = 1'b1;
        tick();
    endtask

    task automatic test_write_during_load();
        VBLANK = 1'b1;
        tick();
        tick();
        cpu_we = 1'b1; cpu_data = 9'h1FF;
        tick();
        cpu_we = 1'b0;
        vectors++;
        if (VBD !== 16'h0040 || VSCRLD !== 1'b1) begin
            miscompares++;
            $display("FAIL write_in_load got VBD=%h VSCRLD=%b exp 0040 1", VBD, VSCRLD);
        end
        tick();
        vectors++;
        if (VBD !== 16'h0040 || VBD_OE !== 1'b1 || VSCRLD !== 1'b0) begin
            miscompares++;
            $display("FAIL write_in_hold got VBD=%h OE=%b VSCRLD=%b exp 0040 1 0", VBD, VBD_OE, VSCRLD);
        end
        tick();
        VBLANK = 1'b0;
        tick(); tick();
        VBLANK = 1'b1;
        tick();
        vectors++;
        if (VBD !== 16'h01FF || VBD_OE !== 1'b1) begin
            miscompares++;
            $display("FAIL next_frame got VBD=%h OE=%b exp 01ff 1", VBD, VBD_OE);
        end
        for (int i = 0; i < 4; i++) tick();
        VBLANK = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int starts;
        bit prev_busy;
        cpu_we = 1'b1; cpu_data = 9'h0AA; cpu_split = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_split = 1'b0;
        HSYNC = 1'b0;
        tick();
        HSYNC = 1'b1; cpu_we = 1'b1; cpu_data = 9'h0BB; cpu_split = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_split = 1'b0; HSYNC = 1'b0;
        tick();
        HSYNC = 1'b1; VBLANK = 1'b1;
        tick();
        cpu_we = 1'b1; cpu_data = 9'h0CC;
        tick();
        cpu_we = 1'b0;
        tick();
        vectors++;
        if (VBD !== 16'h00CC || VBD_OE !== 1'b1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_reload got VBD=%h OE=%b BUSY=%b exp 00cc 1 1", VBD, VBD_OE, BUSY);
        end
        starts = 0;
        prev_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BUSY === 1'b1 && !prev_busy) starts++;
            prev_busy = BUSY;
            vectors++;
            if ({BUSY, VSCRLD, VBD_OE, VBD} !== expected()) begin
                miscompares++;
                $display("FAIL b2b_seq cyc=%0d got=%h exp=%h", cyc, {BUSY, VSCRLD, VBD_OE, VBD}, expected());
            end
        end
        vectors++;
        if (starts !== 0) begin
            miscompares++;
            $display("FAIL b2b_extra_loads got=%0d exp=0", starts);
        end
        VBLANK = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle();
        cpu_we = 1'b1; cpu_data = 9'h055; cpu_split = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_split = 1'b0;
        VBLANK = 1'b1; HSYNC = 1'b0;
        tick();
        vectors++;
        if (VBD !== 16'h0055 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_load got VBD=%h BUSY=%b exp 0055 1", VBD, BUSY);
        end
        HSYNC = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        VBLANK = 1'b0;
        tick();
        HSYNC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (BUSY !== 1'b0 || {BUSY, VSCRLD, VBD_OE, VBD} !== expected()) begin
                miscompares++;
                $display("FAIL same_cycle_split_cleared cyc=%0d got=%h exp=%h", cyc, {BUSY, VSCRLD, VBD_OE, VBD}, expected());
            end
        end
        HSYNC = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        cpu_we = 1'b1; cpu_data = 9'h133; cpu_split = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_split = 1'b0;
        VBLANK = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (VSCRLD !== 1'b0 || VBD_OE !== 1'b0 || VBD !== 16'h0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got VSCRLD=%b OE=%b VBD=%h BUSY=%b exp all 0", VSCRLD, VBD_OE, VBD, BUSY);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (BUSY !== 1'b0 || {BUSY, VSCRLD, VBD_OE, VBD} !== expected()) begin
                miscompares++;
                $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", cyc, {BUSY, VSCRLD, VBD_OE, VBD}, expected());
            end
        end
        VBLANK = 1'b0;
        tick();
        VBLANK = 1'b1;
        tick();
        vectors++;
        if (BUSY !== 1'b1 || VBD_OE !== 1'b1 || VBD !== 16'h0000) begin
            miscompares++;
            $display("FAIL post_reset_frame got BUSY=%b OE=%b VBD=%h exp 1 1 0000", BUSY, VBD_OE, VBD);
        end
        for (int i = 0; i < 4; i++) tick();
        VBLANK = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cpu_we    = ($urandom_range(0, 5) == 0);
            cpu_data  = 9'($urandom);
            cpu_split = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 29) == 0) VBLANK = ~VBLANK;
            if ($urandom_range(0, 3) == 0) HSYNC = ~HSYNC;
            tick();
            vectors++;
            if ({BUSY, VSCRLD, VBD_OE, VBD} !== expected()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {BUSY, VSCRLD, VBD_OE, VBD}, expected());
            end
        end
        cpu_we = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_load();
        test_split();
        test_write_during_load();
        test_back_to_back();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
